// File: rtl/bnn_serial_loader.sv
// bnn_serial_loader: deserialises the synchronised pixel and weight bit streams
// into parallel buffers and hands them to the layer controller via start/valid/ack.
// Optional feature macro: LOADER_POPCNT_EN adds the pix_ones pixel popcount output.
module bnn_serial_loader #(
  parameter int unsigned PIX_BITS = 784,
  parameter int unsigned WGT_BITS = 784,
  localparam int unsigned N_BITS = (PIX_BITS > WGT_BITS) ? PIX_BITS : WGT_BITS,
  localparam int unsigned CNT_W = $clog2(N_BITS + 1),
  localparam int unsigned ONES_W = $clog2(PIX_BITS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                sync_in_p,
  input  logic                sync_in_w,
  input  logic                data_ack,
  output logic [PIX_BITS-1:0] pixels,
  output logic [WGT_BITS-1:0] weights,
  output logic                data_valid,
  output logic                busy,
`ifdef LOADER_POPCNT_EN
  output logic [ONES_W-1:0]   pix_ones,
`endif
  output logic [CNT_W-1:0]    bit_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PIX_BITS-1:0] pix_q, pix_d;
  logic [WGT_BITS-1:0] wgt_q, wgt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [PIX_BITS:0]   pix_sh;
  logic [WGT_BITS:0]   wgt_sh;
`ifdef LOADER_POPCNT_EN
  logic [ONES_W-1:0]   ones_q, ones_d;
`endif

  // Next-state, capture and counter logic
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    wgt_d   = wgt_q;
    cnt_d   = cnt_q;
`ifdef LOADER_POPCNT_EN
    ones_d  = ones_q;
`endif
    // Right shift with the new bit entering at the MSB; first bit ends at [0]
    pix_sh  = {sync_in_p, pix_q};
    wgt_sh  = {sync_in_w, wgt_q};

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
`ifdef LOADER_POPCNT_EN
          ones_d  = '0;
`endif
        end
      end
      ST_LOAD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q < CNT_W'(PIX_BITS)) begin
          pix_d = pix_sh[PIX_BITS:1];
`ifdef LOADER_POPCNT_EN
          ones_d = ones_q + ONES_W'(sync_in_p);
`endif
        end
        if (cnt_q < CNT_W'(WGT_BITS)) begin
          wgt_d = wgt_sh[WGT_BITS:1];
        end
        if (cnt_q == CNT_W'(N_BITS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Ack wins over a simultaneous start; a new start is needed in IDLE
        if (data_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_DONE);
    busy_d  = (state_d == ST_LOAD);
  end

  // State, buffer and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      wgt_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef LOADER_POPCNT_EN
      ones_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      wgt_q   <= wgt_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef LOADER_POPCNT_EN
      ones_q  <= ones_d;
`endif
    end
  end

  assign pixels     = pix_q;
  assign weights    = wgt_q;
  assign bit_cnt    = cnt_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
`ifdef LOADER_POPCNT_EN
  assign pix_ones   = ones_q;
`endif

endmodule
